// File: rtl/biu8_pkg.sv
// rtl/biu8_pkg.sv - shared FSM type, size encodings and constants for biu8_master
package biu8_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned WAIT_LIMIT = 255;

    // the reserved encoding moves a full word
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/biu8_phase_tmr.sv
// rtl/biu8_phase_tmr.sv - loadable down-counter with zero flag, shared by setup/strobe/hold phases
module biu8_phase_tmr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/biu8_master.sv
// rtl/biu8_master.sv - 8-bit strobed port initiator; optional wait handshake under BIU8_MASTER_WAIT_EN
module biu8_master
    import biu8_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_sel,
    output logic        bus_en,
    output logic        bus_wr_n,
    output logic        bus_rd_n
`ifdef BIU8_MASTER_WAIT_EN
    ,
    input  logic        bus_wait_n,
    output logic        rsp_err
`endif
);

    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam bit CFG_OK = (SETUP_CYC >= 1) && (SETUP_CYC <= 15) &&
                            (STROBE_CYC >= 1) && (STROBE_CYC <= 15) &&
                            (HOLD_CYC >= 0) && (HOLD_CYC <= 15) &&
                            (SETUP_CYC <= (1 << CNT_W)) && (STROBE_CYC <= (1 << CNT_W)) &&
                            (HOLD_CYC <= (1 << CNT_W));

    cfg_range: assert property (@(posedge clk) CFG_OK)
        else $error("biu8_master: timing parameter out of range");

    state_t            state, state_nxt;
    logic              we_q, we_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [2:0]        count_q;
    logic [1:0]        idx_q, idx_nxt;
    logic [31:0]       acc_q, acc_nxt;
    logic              tmr_load, tmr_zero;
    logic [CNT_W-1:0]  tmr_val;
    logic              accept, last_byte, final_strobe, strobe_done, stall, expire;
    logic              sel_d, en_d, wr_n_d, rd_n_d, rsp_valid_d;
    logic [7:0]        dout_d;
    logic [31:0]       rsp_rdata_d;

    biu8_phase_tmr #(.CNT_W(CNT_W)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign accept       = req_valid && (state == IDLE);
    assign last_byte    = ({1'b0, idx_q} == (count_q - 3'd1));
    assign final_strobe = (state == STROBE) && tmr_zero;
    assign strobe_done  = final_strobe && !stall;
    assign we_nxt       = accept ? req_we : we_q;
    assign wdata_nxt    = accept ? req_wdata : wdata_q;
    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);

`ifdef BIU8_MASTER_WAIT_EN
    logic [7:0] wait_cnt;
    logic       err_q, err_nxt;

    // the strobe stretches in its final cycle until the peripheral releases wait or the limit runs out
    assign stall   = final_strobe && !bus_wait_n && (wait_cnt != 8'(WAIT_LIMIT));
    assign expire  = final_strobe && !bus_wait_n && (wait_cnt == 8'(WAIT_LIMIT));
    assign err_nxt = accept ? 1'b0 : (err_q | expire);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= stall ? wait_cnt + 8'd1 : 8'd0;
            err_q    <= err_nxt;
            rsp_err  <= (state_nxt == DONE) && err_nxt;
        end
    end
`else
    assign stall  = 1'b0;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        acc_nxt   = acc_q;
        tmr_load  = 1'b0;
        tmr_val   = LD_SETUP;
        case (state)
            IDLE: if (req_valid) begin
                state_nxt = SETUP;
                tmr_load  = 1'b1;
                idx_nxt   = 2'd0;
                acc_nxt   = '0;
            end
            SETUP: if (tmr_zero) begin
                state_nxt = STROBE;
                tmr_load  = 1'b1;
                tmr_val   = LD_STROBE;
            end
            STROBE: if (strobe_done) begin
                if (!we_q) acc_nxt[{idx_q, 3'b000} +: 8] = expire ? 8'hFF : bus_din;
                if (HOLD_CYC > 0) begin
                    state_nxt = HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_HOLD;
                end else if (last_byte) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETUP;
                    idx_nxt   = idx_q + 2'd1;
                    tmr_load  = 1'b1;
                end
            end
            HOLD: if (tmr_zero) begin
                if (last_byte) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETUP;
                    idx_nxt   = idx_q + 2'd1;
                    tmr_load  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bus outputs are decoded from the next state and registered, so they change with the state edge
    always_comb begin
        sel_d       = 1'b1;
        en_d        = 1'b0;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        dout_d      = bus_dout;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        case (state_nxt)
            SETUP, STROBE, HOLD: begin
                sel_d = !we_nxt;
                en_d  = we_nxt;
                if (we_nxt) dout_d = wdata_nxt[{idx_nxt, 3'b000} +: 8];
                if (state_nxt == STROBE) begin
                    wr_n_d = !we_nxt;
                    rd_n_d = we_nxt;
                end
            end
            DONE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? 32'd0 : acc_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            wdata_q   <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            bus_dout  <= '0;
            bus_sel   <= 1'b1;
            bus_en    <= 1'b0;
            bus_wr_n  <= 1'b1;
            bus_rd_n  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            we_q      <= we_nxt;
            wdata_q   <= wdata_nxt;
            count_q   <= accept ? size_to_count(req_size) : count_q;
            idx_q     <= idx_nxt;
            acc_q     <= acc_nxt;
            bus_dout  <= dout_d;
            bus_sel   <= sel_d;
            bus_en    <= en_d;
            bus_wr_n  <= wr_n_d;
            bus_rd_n  <= rd_n_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_biu8_master.sv
// tb/tb_biu8_master.sv - directed bench for biu8_master; wait cases under BIU8_MASTER_WAIT_EN
module tb_biu8_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b, req_we;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [7:0]  bus_din;

    logic        req_ready_a, rsp_valid_a, busy_a, bus_sel_a, bus_en_a, bus_wr_n_a, bus_rd_n_a;
    logic [31:0] rsp_rdata_a;
    logic [7:0]  bus_dout_a;
    logic        req_ready_b, rsp_valid_b, busy_b, bus_sel_b, bus_en_b, bus_wr_n_b, bus_rd_n_b;
    logic [31:0] rsp_rdata_b;
    logic [7:0]  bus_dout_b;
`ifdef BIU8_MASTER_WAIT_EN
    logic        bus_wait_n;
    logic        rsp_err_a, rsp_err_b;
`endif

    always #5 clk = ~clk;

    biu8_master u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
        .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
        .busy(busy_a), .bus_dout(bus_dout_a), .bus_din(bus_din), .bus_sel(bus_sel_a), .bus_en(bus_en_a),
        .bus_wr_n(bus_wr_n_a), .bus_rd_n(bus_rd_n_a)
`ifdef BIU8_MASTER_WAIT_EN
        , .bus_wait_n(bus_wait_n), .rsp_err(rsp_err_a)
`endif
    );

    biu8_master #(.HOLD_CYC(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .busy(busy_b), .bus_dout(bus_dout_b), .bus_din(bus_din), .bus_sel(bus_sel_b), .bus_en(bus_en_b),
        .bus_wr_n(bus_wr_n_b), .bus_rd_n(bus_rd_n_b)
`ifdef BIU8_MASTER_WAIT_EN
        , .bus_wait_n(bus_wait_n), .rsp_err(rsp_err_b)
`endif
    );

    logic        use_b;
    logic        obs_ready, obs_valid, obs_sel, obs_en, obs_wr_n, obs_rd_n;
    logic [31:0] obs_rdata;
    logic [7:0]  obs_dout;
    assign obs_ready = use_b ? req_ready_b : req_ready_a;
    assign obs_valid = use_b ? rsp_valid_b : rsp_valid_a;
    assign obs_rdata = use_b ? rsp_rdata_b : rsp_rdata_a;
    assign obs_sel   = use_b ? bus_sel_b   : bus_sel_a;
    assign obs_en    = use_b ? bus_en_b    : bus_en_a;
    assign obs_wr_n  = use_b ? bus_wr_n_b  : bus_wr_n_a;
    assign obs_rd_n  = use_b ? bus_rd_n_b  : bus_rd_n_a;
    assign obs_dout  = use_b ? bus_dout_b  : bus_dout_a;
`ifdef BIU8_MASTER_WAIT_EN
    logic obs_err;
    assign obs_err = use_b ? rsp_err_b : rsp_err_a;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          lat, wr_pulses, rd_pulses, wr_low, rd_low, sel_bad, overlap, wait_len;
    logic        rdy_at_done, err_seen;
    logic [31:0] rdata;
    logic [7:0]  wr_bytes[$];
    int          runs[$];
    logic [7:0]  din_tab[4];

    task automatic run_txn(input bit on_b, input logic we, input logic [1:0] size,
                           input logic [31:0] wdata, input int max_cyc);
        int         run_len, release_k;
        logic [7:0] run_val;
        logic       prev_wr, prev_rd;
        use_b = on_b;
        lat = 0; wr_pulses = 0; rd_pulses = 0; wr_low = 0; rd_low = 0;
        sel_bad = 0; overlap = 0; rdy_at_done = 1'bx; err_seen = 1'b0; rdata = 'x;
        wr_bytes.delete();
        runs.delete();
        @(negedge clk);
        req_we = we; req_size = size; req_wdata = wdata;
        if (on_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        prev_wr = 1'b1; prev_rd = 1'b1; run_len = 0; run_val = 8'h00; release_k = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
`ifdef BIU8_MASTER_WAIT_EN
            if (k == release_k) bus_wait_n = 1'b1;
`endif
            if (!obs_wr_n) wr_low++;
            if (!obs_wr_n && prev_wr) begin
                wr_pulses++;
                wr_bytes.push_back(obs_dout);
                if (obs_sel !== 1'b0) sel_bad++;
            end
            if (!obs_rd_n) rd_low++;
            if (!obs_rd_n && prev_rd) begin
                bus_din = din_tab[rd_pulses % 4];
                rd_pulses++;
`ifdef BIU8_MASTER_WAIT_EN
                if (wait_len > 0) begin
                    bus_wait_n = 1'b0;
                    release_k  = k + wait_len + 1;
                end
`endif
            end
            if (!we && obs_sel !== 1'b1) sel_bad++;
            if (!obs_wr_n && !obs_rd_n) overlap++;
            if (obs_en) begin
                if (run_len > 0 && obs_dout == run_val) begin
                    run_len++;
                end else begin
                    if (run_len > 0) runs.push_back(run_len);
                    run_val = obs_dout;
                    run_len = 1;
                end
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            prev_wr = obs_wr_n;
            prev_rd = obs_rd_n;
            if (obs_valid) begin
                lat = k;
                rdata = obs_rdata;
                rdy_at_done = obs_ready;
`ifdef BIU8_MASTER_WAIT_EN
                err_seen = obs_err;
`endif
                break;
            end
        end
        if (run_len > 0) runs.push_back(run_len);
`ifdef BIU8_MASTER_WAIT_EN
        bus_wait_n = 1'b1;
`endif
    endtask

    initial begin
        int strobe_act, stray_valid;
        rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_wdata = '0; bus_din = 8'h00; use_b = 1'b0; wait_len = 0;
        din_tab[0] = 8'h00; din_tab[1] = 8'h00; din_tab[2] = 8'h00; din_tab[3] = 8'h00;
`ifdef BIU8_MASTER_WAIT_EN
        bus_wait_n = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", {31'd0, req_ready_a}, 32'd1);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid_a}, 32'd0);
        check("rst_rdata", rsp_rdata_a, 32'd0);
        check("rst_dout", {24'd0, bus_dout_a}, 32'd0);
        check("rst_sel", {31'd0, bus_sel_a}, 32'd1);
        check("rst_en", {31'd0, bus_en_a}, 32'd0);
        check("rst_wr_n", {31'd0, bus_wr_n_a}, 32'd1);
        check("rst_rd_n", {31'd0, bus_rd_n_a}, 32'd1);
        strobe_act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus_wr_n_a || !bus_rd_n_a || rsp_valid_a || !req_ready_a) strobe_act++;
        end
        check("idle_quiet", strobe_act, 32'd0);

        run_txn(1'b0, 1'b1, 2'd0, 32'h0000_00A5, 40);
        check("bw_lat", lat, 32'd5);
        check("bw_pulses", wr_pulses, 32'd1);
        check("bw_wr_low", wr_low, 32'd2);
        check("bw_rd_low", rd_low, 32'd0);
        check("bw_byte", {24'd0, wr_bytes.size() > 0 ? wr_bytes[0] : 8'hxx}, 32'hA5);
        check("bw_sel", sel_bad, 32'd0);
        check("bw_rdata", rdata, 32'd0);
        check("bw_run", runs.size() > 0 ? runs[0] : -1, 32'd4);
        check("bw_ready_done", {31'd0, rdy_at_done}, 32'd0);
        @(negedge clk);
        check("bw_ready_after", {31'd0, req_ready_a}, 32'd1);

        din_tab[0] = 8'h11; din_tab[1] = 8'h22; din_tab[2] = 8'h33; din_tab[3] = 8'h44;
        run_txn(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 60);
        check("wr_lat", lat, 32'd17);
        check("wr_pulses", rd_pulses, 32'd4);
        check("wr_rd_low", rd_low, 32'd8);
        check("wr_wr_low", wr_low, 32'd0);
        check("wr_sel", sel_bad, 32'd0);
        check("wr_overlap", overlap, 32'd0);
        check("wr_rdata", rdata, 32'h4433_2211);

        din_tab[0] = 8'hAA; din_tab[1] = 8'hBB;
        run_txn(1'b0, 1'b0, 2'd1, 32'd0, 40);
        check("hr_lat", lat, 32'd9);
        check("hr_rdata", rdata, 32'h0000_BBAA);

        run_txn(1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF, 60);
        check("rsv_lat", lat, 32'd17);
        check("rsv_pulses", wr_pulses, 32'd4);
        check("rsv_bytes", wr_bytes.size() == 4 ? {wr_bytes[3], wr_bytes[2], wr_bytes[1], wr_bytes[0]} : 32'hx,
              32'hDEAD_BEEF);

        run_txn(1'b1, 1'b1, 2'd1, 32'h0000_BEEF, 40);
        check("h0_lat", lat, 32'd7);
        check("h0_bytes", wr_bytes.size() == 2 ? {16'd0, wr_bytes[1], wr_bytes[0]} : 32'hx, 32'h0000_BEEF);
        check("h0_runs", runs.size(), 32'd2);
        check("h0_run0", runs.size() > 0 ? runs[0] : -1, 32'd3);
        check("h0_run1", runs.size() > 1 ? runs[1] : -1, 32'd3);
        use_b = 1'b0;

        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_wdata = 32'h1234_5678; req_valid_a = 1'b1;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_strobe1", {31'd0, bus_wr_n_a}, 32'd0);
        @(negedge clk);
        check("mid_strobe2", {31'd0, bus_wr_n_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_wr_n", {31'd0, bus_wr_n_a}, 32'd1);
        check("mid_valid", {31'd0, rsp_valid_a}, 32'd0);
        check("mid_sel", {31'd0, bus_sel_a}, 32'd1);
        check("mid_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        stray_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_a) stray_valid++;
        end
        check("mid_no_rsp", stray_valid, 32'd0);
        run_txn(1'b0, 1'b1, 2'd0, 32'h0000_005A, 40);
        check("post_lat", lat, 32'd5);
        check("post_byte", {24'd0, wr_bytes.size() > 0 ? wr_bytes[0] : 8'hxx}, 32'h5A);

`ifdef BIU8_MASTER_WAIT_EN
        din_tab[0] = 8'h3C;
        wait_len = 3;
        run_txn(1'b0, 1'b0, 2'd0, 32'd0, 60);
        check("wt_lat", lat, 32'd8);
        check("wt_rd_low", rd_low, 32'd5);
        check("wt_rdata", rdata, 32'h0000_003C);
        check("wt_err", {31'd0, err_seen}, 32'd0);
        wait_len = 100000;
        run_txn(1'b0, 1'b0, 2'd0, 32'd0, 400);
        check("to_lat", lat, 32'd260);
        check("to_err", {31'd0, err_seen}, 32'd1);
        check("to_rdata", rdata, 32'h0000_00FF);
        wait_len = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/biu8_master.md
Name: biu8_master

Overview:
- Synchronous initiator for the 8-bit strobed parallel port bus; the controller side that drives the strobes, read/write and enable lines a byte-wide port peripheral responds to.
- Accepts one byte, halfword or word request from the SoC internal bus.
- Splits the request into little-endian byte transfers with programmable setup, strobe and hold timing.
- On reads, gathers the returned bytes into a 32-bit response.

Parameters:
- SETUP_CYC, 1, cycles data/direction are stable before the strobe falls (1..15)
- STROBE_CYC, 2, cycles the strobe is held low (1..15)
- HOLD_CYC, 1, cycles data/direction are held after the strobe rises (0..15)
- CNT_W, 4, width of the shared phase counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word)
- req_wdata  in  32  write data, byte 0 in [7:0]
- rsp_valid  out  1  one-cycle pulse when the transaction completes
- rsp_rdata  out  32  read data, zero-extended above the transferred size; 0 for writes
- busy  out  1  transaction in progress
- bus_dout  out  8  byte driven to the port
- bus_din  in  8  byte sampled from the port
- bus_sel  out  1  direction: 1 = bus tri-stated/input (read), 0 = master drives (write)
- bus_en  out  1  write-enable qualifier, high during write transfers
- bus_wr_n  out  1  active-low write strobe; the rising edge commits the write
- bus_rd_n  out  1  active-low read strobe

Behaviour:
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, bus_dout=0, bus_sel=1, bus_en=0, bus_wr_n=1, bus_rd_n=1, FSM=IDLE, counters=0.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - A request is accepted when req_valid & req_ready.
  - On accept, latch we, wdata and byte count (1, 2 or 4), clear the byte index and the read accumulator, then go to SETUP.
- SETUP:
  - For writes, bus_sel=0, bus_en=1 and bus_dout = wdata byte[idx].
  - For reads, bus_sel=1 and bus_en=0.
  - Both strobes stay high.
  - After SETUP_CYC cycles, go to STROBE.
- STROBE:
  - The selected strobe (bus_wr_n or bus_rd_n) is low for exactly STROBE_CYC cycles.
  - On a read, bus_din is sampled in the final STROBE cycle into accumulator byte[idx].
  - Then go to HOLD, or straight to the next step if HOLD_CYC=0.
- HOLD:
  - Strobe high; bus_dout, bus_sel and bus_en unchanged for HOLD_CYC cycles.
  - Then, if idx < count-1: idx+1 and go to SETUP.
  - Otherwise go to DONE.
- DONE:
  - For one cycle: rsp_valid=1, rsp_rdata = accumulator (read) or 0 (write).
  - bus_sel=1, bus_en=0.
  - Next state is IDLE.
- Latency per byte: SETUP_CYC + STROBE_CYC + HOLD_CYC. Total latency from accept to rsp_valid: count × (per-byte latency) + 1 cycle.
- Back-to-back: req_ready returns high the cycle after DONE. No request is accepted during DONE.
- Strobe ordering: bus_wr_n and bus_rd_n are never low at the same time. No strobe falls in the same cycle that bus_sel or bus_dout changes.
- All bus outputs are registered (glitch-free).
- req_valid while busy is ignored; the request is not queued.
- Reset mid-transaction returns to the reset values on the next edge. A strobe in progress is released high; no rsp_valid is issued.
- Phase counter: loads (phase length - 1) on phase entry and counts down to 0. Width CNT_W. Parameters outside their range are a configuration error; a simulation assertion fires.

Optional Feature:
- Macro: BIU8_MASTER_WAIT_EN.
- When defined:
  - Adds input bus_wait_n (1 bit, active low).
  - In the final STROBE cycle, if bus_wait_n=0, the strobe stays low and the counter holds until bus_wait_n=1. Read sampling happens in the cycle bus_wait_n is seen high.
  - A wait-cycle limit of 255 applies. On expiry, complete the byte with a 0xFF read value and set output rsp_err=1 together with rsp_valid.
- When not defined: the port and rsp_err are absent, and timing is fixed by the parameters.

Decomposition:
- Package biu8_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, DONE);
  - req_size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the size-to-byte-count function;
  - the wait-limit constant 255.
- One sub-module, biu8_phase_tmr: a loadable down-counter with a zero flag, shared by all three phases.

Test Plan:
- Reset, then idle: all outputs at their reset values; req_ready=1; no strobe activity for 20 cycles.
- Byte write: req_size=0, req_wdata=0x000000A5, defaults.
  - Exactly one bus_wr_n low pulse of 2 cycles with bus_dout=0xA5 and bus_sel=0.
  - rsp_valid 5 cycles after accept, rsp_rdata=0.
- Word read: bus_din model returns 0x11, 0x22, 0x33, 0x44 on successive strobes.
  - Four bus_rd_n pulses, bus_sel=1 throughout.
  - rsp_rdata=0x44332211, rsp_valid 17 cycles after accept.
- Halfword write 0x0000BEEF with HOLD_CYC=0: bus_dout sequence 0xEF then 0xBE; bus_dout stays stable for SETUP+STROBE cycles around each pulse.
- Reset asserted during the second STROBE cycle of a word write: bus_wr_n=1 the next cycle, no rsp_valid, and a new request is accepted afterwards.
- With BIU8_MASTER_WAIT_EN:
  - bus_wait_n low for 3 cycles: the strobe stretches by 3 cycles and the read byte is sampled after release.
  - bus_wait_n held low: rsp_err=1, rsp_rdata=0x000000FF (byte read).
